hazard_scoreboard: RTL
======================

Name: hazard_scoreboard

Overview:
- Stall/forward controller for the 5-stage MIPS pipeline.
- Producer side: W-stage control emits RegWr/WD-select/Tnew. This block is the consumer side: it takes each D-stage instruction's read operands (rs/rt with Tuse) and its write intent.
- Keeps its own shadow E/M/W scoreboard of pending register writes.
- Emits a pipeline stall plus forwarding mux selects for the D, E and M stages.

Parameters:
- AW, 5, register address width.
- TW, 2, Tnew/Tuse counter width.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- rs_D  in  AW  D-stage rs address.
- rt_D  in  AW  D-stage rt address.
- rs_use_D  in  1  instruction reads rs.
- rt_use_D  in  1  instruction reads rt.
- tuse_rs_D  in  TW  cycles until rs is consumed (0 = in D).
- tuse_rt_D  in  TW  cycles until rt is consumed.
- wa_D  in  AW  destination register.
- regwr_D  in  1  instruction writes the register file.
- tnew_D  in  TW  Tnew on entry to E (ALU=1, lw=2, jal=0).
- stall  out  1  freeze PC and D register, bubble into E.
- fwd_rs_D, fwd_rt_D  out  2  D-stage source: 0 RF, 1 E(PC8@E), 2 M, 3 W.
- fwd_rs_E, fwd_rt_E  out  2  E-stage ALU source: 0 pipeline reg, 1 M, 2 W.
- fwd_rt_M  out  1  DM write data: 0 pipeline reg, 1 W.

Behaviour:
- Scoreboard slots E, M, W. Each slot holds {valid, regwr, wa, tnew, rs, rt}.
- Update on posedge clk:
  - W <= M, with tnew forced to 0.
  - M <= E, with tnew = (E.tnew==0) ? 0 : E.tnew-1 (saturating).
  - E <= stall ? bubble (valid=0, regwr=0) : {1, regwr_D, wa_D, tnew_D, rs_D, rt_D}.
- A slot "writes r" iff valid && regwr && wa==r && r!=0. Register $0 never matches, never stalls, never forwards.
- stall (combinational), for X in {rs, rt}:
  - Stall if X_use_D and (E writes X with E.tnew > tuse_X_D, or M writes X with M.tnew > tuse_X_D).
  - W never causes a stall.
- fwd_X_D: priority E (if E.tnew==0) > M (if M.tnew==0) > W > RF.
  - A younger matching slot with tnew!=0 blocks older sources. Stall covers that case.
- fwd_X_E: source is E.rs/E.rt. Priority M (match && M.tnew==0) > W > 0.
- fwd_rt_M: 1 iff W writes M.rt.
- Outputs are fully combinational from slots and D inputs. No extra latency beyond the slot registers.
- Reset (async, any time): all slots valid=0, regwr=0, tnew=0, addresses=0.
  - Hence stall=0 and all fwd=0 immediately, independent of clk.
- Simultaneous matches in several slots: youngest wins (E > M > W).
- Stall held for several cycles: D inputs are held by the pipeline. Bubbles keep entering E until the producer's tnew has drained.

Optional Feature:
- HAZ_RF_BYPASS_EN defined: the register file bypasses W->D internally. fwd_X_D never encodes 3; a W match yields 0.
- Undefined: W matches yield fwd_X_D=3 as specified above.
- E/M forwarding and stall are unaffected by the macro.

Decomposition:
- Shared header (head.v) gains FWD_D_RF/E/M/W, FWD_E_REG/M/W, FWD_M_REG/W, and TNEW_ALU=1/TNEW_LW=2/TNEW_PC=0.
- Existing WD_ALU/WD_DM/WD_PC4 defines are untouched.
- One sub-module, hz_slot: a single scoreboard register with saturating tnew decrement, bubble load and async reset. Instantiated three times.

Test Plan:
- Back-to-back ALU use: addu $1,$2,$3 ; addu $4,$1,$5 (tuse rs=1) -> stall=0. Next cycle fwd_rs_E=1 (from M).
- Load-use: lw $1,0($0) ; addu $4,$1,$5 -> exactly 1 stall cycle (E bubble). Then fwd_rs_E=2 (from W).
- Branch after load: lw $1 ; beq $1,$2 (tuse=0) -> 2 stall cycles. Then fwd_rs_D=3, or 0 with HAZ_RF_BYPASS_EN.
- jal then jr $31 -> stall=0, fwd_rs_D=1 (PC8@E).
- Store data: lw $1 ; sw $1,0($2) (rt tuse=2) -> stall=0. When sw reaches M, fwd_rt_M=1.
- Writes to $0 (addu $0 ; addu $4,$0,$0) -> stall=0, all fwd=0. Assert reset mid-stall -> stall drops to 0 asynchronously, slots cleared.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared encodings for the hazard scoreboard: forwarding mux selects, Tnew classes
// and the per-slot Tnew update mode.
package hazard_scoreboard_pkg;

  localparam logic [1:0] FWD_D_RF  = 2'd0;
  localparam logic [1:0] FWD_D_E   = 2'd1;
  localparam logic [1:0] FWD_D_M   = 2'd2;
  localparam logic [1:0] FWD_D_W   = 2'd3;

  localparam logic [1:0] FWD_E_REG = 2'd0;
  localparam logic [1:0] FWD_E_M   = 2'd1;
  localparam logic [1:0] FWD_E_W   = 2'd2;

  localparam logic       FWD_M_REG = 1'b0;
  localparam logic       FWD_M_W   = 1'b1;

  localparam int TNEW_PC  = 0;
  localparam int TNEW_ALU = 1;
  localparam int TNEW_LW  = 2;

  // How a slot transforms the incoming Tnew: E keeps it, M decrements, W clears.
  typedef enum logic [1:0] {
    TN_KEEP = 2'd0,
    TN_DEC  = 2'd1,
    TN_CLR  = 2'd2
  } tnew_mode_e;

endpackage

// File: rtl/hazard_scoreboard_slot.sv
// hz_slot: one scoreboard register (E, M or W) with bubble load and Tnew update.
module hz_slot
  import hazard_scoreboard_pkg::*;
#(
  parameter int         AW   = 5,
  parameter int         TW   = 2,
  parameter tnew_mode_e MODE = TN_KEEP
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          bubble,
  input  logic          in_valid,
  input  logic          in_regwr,
  input  logic [AW-1:0] in_wa,
  input  logic [TW-1:0] in_tnew,
  input  logic [AW-1:0] in_rs,
  input  logic [AW-1:0] in_rt,
  output logic          valid,
  output logic          regwr,
  output logic [AW-1:0] wa,
  output logic [TW-1:0] tnew,
  output logic [AW-1:0] rs,
  output logic [AW-1:0] rt
);

  logic          valid_d, valid_q, regwr_d, regwr_q;
  logic [AW-1:0] wa_d, wa_q, rs_d, rs_q, rt_d, rt_q;
  logic [TW-1:0] tnew_d, tnew_q;

  always_comb begin
    valid_d = in_valid;
    regwr_d = in_regwr;
    wa_d    = in_wa;
    rs_d    = in_rs;
    rt_d    = in_rt;
    tnew_d  = in_tnew;
    case (MODE)
      TN_DEC:  tnew_d = (in_tnew == '0) ? '0 : in_tnew - TW'(1);
      TN_CLR:  tnew_d = '0;
      default: tnew_d = in_tnew;
    endcase
    // A bubble is an all-zero slot so it can never match any source register.
    if (bubble) begin
      valid_d = 1'b0;
      regwr_d = 1'b0;
      wa_d    = '0;
      rs_d    = '0;
      rt_d    = '0;
      tnew_d  = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      regwr_q <= 1'b0;
      wa_q    <= '0;
      rs_q    <= '0;
      rt_q    <= '0;
      tnew_q  <= '0;
    end else begin
      valid_q <= valid_d;
      regwr_q <= regwr_d;
      wa_q    <= wa_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      tnew_q  <= tnew_d;
    end
  end

  assign valid = valid_q;
  assign regwr = regwr_q;
  assign wa    = wa_q;
  assign tnew  = tnew_q;
  assign rs    = rs_q;
  assign rt    = rt_q;

endmodule

// File: rtl/hazard_scoreboard.sv
// Consumer-side stall/forward controller for the 5-stage pipeline, built on a shadow
// E/M/W scoreboard. Define HAZ_RF_BYPASS_EN when the register file bypasses W->D itself.
module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int AW = 5,
  parameter int TW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [AW-1:0] rs_D,
  input  logic [AW-1:0] rt_D,
  input  logic          rs_use_D,
  input  logic          rt_use_D,
  input  logic [TW-1:0] tuse_rs_D,
  input  logic [TW-1:0] tuse_rt_D,
  input  logic [AW-1:0] wa_D,
  input  logic          regwr_D,
  input  logic [TW-1:0] tnew_D,
  output logic          stall,
  output logic [1:0]    fwd_rs_D,
  output logic [1:0]    fwd_rt_D,
  output logic [1:0]    fwd_rs_E,
  output logic [1:0]    fwd_rt_E,
  output logic          fwd_rt_M
);

  // Slot index 0 = E (youngest), 1 = M, 2 = W.
  logic [2:0]          v, rw;
  logic [2:0][AW-1:0]  wa, rs, rt;
  logic [2:0][TW-1:0]  tn;

  for (genvar i = 0; i < 3; i++) begin : g_slot
    logic          in_v, in_rw;
    logic [AW-1:0] in_wa, in_rs, in_rt;
    logic [TW-1:0] in_tn;
    if (i == 0) begin : g_head
      assign in_v  = 1'b1;
      assign in_rw = regwr_D;
      assign in_wa = wa_D;
      assign in_rs = rs_D;
      assign in_rt = rt_D;
      assign in_tn = tnew_D;
    end else begin : g_chain
      assign in_v  = v[i-1];
      assign in_rw = rw[i-1];
      assign in_wa = wa[i-1];
      assign in_rs = rs[i-1];
      assign in_rt = rt[i-1];
      assign in_tn = tn[i-1];
    end
    hz_slot #(.AW(AW), .TW(TW), .MODE(tnew_mode_e'(i))) u_slot (
      .clk      (clk),
      .reset    (reset),
      .bubble   ((i == 0) ? stall : 1'b0),
      .in_valid (in_v),
      .in_regwr (in_rw),
      .in_wa    (in_wa),
      .in_tnew  (in_tn),
      .in_rs    (in_rs),
      .in_rt    (in_rt),
      .valid    (v[i]),
      .regwr    (rw[i]),
      .wa       (wa[i]),
      .tnew     (tn[i]),
      .rs       (rs[i]),
      .rt       (rt[i])
    );
  end

  function automatic logic [2:0] hits(input logic [AW-1:0] r);
    for (int i = 0; i < 3; i++)
      hits[i] = v[i] && rw[i] && (wa[i] == r) && (r != '0);
  endfunction

  // Youngest match decides; a younger producer not yet ready falls back to RF while stalled.
  function automatic logic [1:0] sel_d(input logic [2:0] h);
    if (h[0])      sel_d = (tn[0] == '0) ? FWD_D_E : FWD_D_RF;
    else if (h[1]) sel_d = (tn[1] == '0) ? FWD_D_M : FWD_D_RF;
`ifdef HAZ_RF_BYPASS_EN
    else           sel_d = FWD_D_RF;
`else
    else if (h[2]) sel_d = FWD_D_W;
    else           sel_d = FWD_D_RF;
`endif
  endfunction

  function automatic logic [1:0] sel_e(input logic [2:0] h);
    if (h[1] && tn[1] == '0) sel_e = FWD_E_M;
    else if (h[2])           sel_e = FWD_E_W;
    else                     sel_e = FWD_E_REG;
  endfunction

  function automatic logic must_wait(input logic use_x, input logic [2:0] h,
                                     input logic [TW-1:0] tuse);
    must_wait = use_x && ((h[0] && tn[0] > tuse) || (h[1] && tn[1] > tuse));
  endfunction

  logic [2:0] h_rs_d, h_rt_d, h_rs_e, h_rt_e, h_rt_m;

  always_comb begin
    h_rs_d   = hits(rs_D);
    h_rt_d   = hits(rt_D);
    h_rs_e   = hits(rs[0]);
    h_rt_e   = hits(rt[0]);
    h_rt_m   = hits(rt[1]);
    stall    = must_wait(rs_use_D, h_rs_d, tuse_rs_D) || must_wait(rt_use_D, h_rt_d, tuse_rt_D);
    fwd_rs_D = sel_d(h_rs_d);
    fwd_rt_D = sel_d(h_rt_d);
    fwd_rs_E = sel_e(h_rs_e);
    fwd_rt_E = sel_e(h_rt_e);
    fwd_rt_M = h_rt_m[2] ? FWD_M_W : FWD_M_REG;
  end

endmodule
